// File: rtl/mips_main_control_if.sv
// Control bundle between the multi-cycle main control FSM and the MIPS datapath.
//   opcode, mem_ready    : datapath -> control (IR[31:26], memory handshake)
//   alu_op .. mem_to_reg : control -> datapath enables and mux selects
//   fault, state         : control -> fault pulse and debug state
// master = the control FSM, slave = the datapath side.
interface mips_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] fault;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output alu_op, alu_src_a, alu_src_b, imm_zext, pc_src, pc_write, pc_write_cond,
           branch_ne, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, fault, state
  );

  modport slave (
    output opcode, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, imm_zext, pc_src, pc_write, pc_write_cond,
           branch_ne, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, fault, state
  );
endinterface

// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory ready handshake with a watchdog that raises a bus-timeout fault.
//   i_clk : clock, rising edge
//   i_rst : synchronous reset, active-high (forces all outputs to 0 that cycle)
//   bus   : control bundle (opcode/mem_ready in, datapath controls/fault/state out)
// Outputs are a Moore decode of the state; only ir_write/pc_write in FETCH follow mem_ready.
module mips_main_control #(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mips_main_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    EXEC_I   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    FAULT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_BUS     = 2'b10;

  // Last wait cycle: without ready here the access is abandoned.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [1:0]           fault_q, fault_d;

  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       pc_write_cond;
  logic       branch_ne;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] fault;
  logic [3:0] state_out;
  logic [2:0] imm_op;
  logic       imm_zx;

  // State, watchdog and latched fault code
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FETCH;
      wdog_q  <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  // Logical-immediate ALU op and extension mode
  always_comb begin
    imm_op = 3'b000;
    imm_zx = 1'b0;
    case (bus.opcode)
      OP_ANDI: begin imm_op = 3'b100; imm_zx = 1'b1; end
      OP_ORI:  begin imm_op = 3'b101; imm_zx = 1'b1; end
      OP_XORI: begin imm_op = 3'b110; imm_zx = 1'b1; end
      default: begin imm_op = 3'b000; imm_zx = 1'b0; end
    endcase
  end

  // Next state and output decode; watchdog defaults to clear so any transition resets it
  always_comb begin
    state_d       = state_q;
    wdog_d        = '0;
    fault_d       = fault_q;
    alu_op        = 3'b000;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    fault         = 2'b00;
    state_out     = state_q;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (wdog_q == WDOG_LAST) begin
          fault_d = FAULT_BUS;
          state_d = FAULT;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:                           state_d = EXEC_R;
          OP_LW, OP_SW:                       state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:                     state_d = BRANCH;
          OP_J:                               state_d = JUMP;
          OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_d = EXEC_I;
          default: begin
            fault_d = FAULT_ILLEGAL;
            state_d = FAULT;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b011;
        state_d   = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        iord      = 1'b1;
        mem_read  = (state_q == MEM_RD);
        mem_write = (state_q == MEM_WR);
        if (bus.mem_ready) begin
          state_d = (state_q == MEM_RD) ? MEM_WB : FETCH;
        end else if (wdog_q == WDOG_LAST) begin
          fault_d = FAULT_BUS;
          state_d = FAULT;
        end else begin
          wdog_d = wdog_q + TIMEOUT_W'(1);
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = imm_op;
        imm_zext  = imm_zx;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        alu_op    = imm_op;
        imm_zext  = imm_zx;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = (bus.opcode == OP_BNE);
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = FETCH;
      end
      FAULT: begin
        fault   = fault_q;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset cycle: quiet bus regardless of the stale state
    if (i_rst) begin
      alu_op        = 3'b000;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      imm_zext      = 1'b0;
      pc_src        = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      fault         = 2'b00;
      state_out     = 4'd0;
    end
  end

  assign bus.alu_op        = alu_op;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.imm_zext      = imm_zext;
  assign bus.pc_src        = pc_src;
  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.branch_ne     = branch_ne;
  assign bus.iord          = iord;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.reg_write     = reg_write;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.fault         = fault;
  assign bus.state         = state_out;

endmodule

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: each driven cycle pushes the expected output vector
// (built from the state/output table) to a queue; a negedge monitor pops and compares.
module tb_mips_main_control;

  localparam logic [5:0] R_T   = 6'b000000;
  localparam logic [5:0] J_OP  = 6'b000010;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] ILL   = 6'b111111;

  logic clk;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;
  logic [24:0] sb[$];
  logic [24:0] obs;
  logic [24:0] e;

  mips_main_control_if bus ();

  mips_main_control #(.TIMEOUT_W(8), .MEM_TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.imm_zext, bus.pc_src,
                bus.pc_write, bus.pc_write_cond, bus.branch_ne, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.fault, bus.state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected outputs for one cycle, straight from the per-state control table
  function automatic logic [24:0] model(input logic [3:0] st, input logic [5:0] opc,
                                        input logic rdy, input logic [1:0] fc);
    logic [2:0] op;  logic sa; logic [1:0] sbs; logic zx; logic [1:0] ps;
    logic pw, pwc, bn, io, mr, mw, irw, rw, rd, m2r; logic [1:0] f;
    op = '0; sa = 0; sbs = '0; zx = 0; ps = '0; pw = 0; pwc = 0; bn = 0;
    io = 0; mr = 0; mw = 0; irw = 0; rw = 0; rd = 0; m2r = 0; f = '0;
    case (st)
      4'd0:  begin mr = 1; sbs = 2'b01; irw = rdy; pw = rdy; end
      4'd1:  sbs = 2'b11;
      4'd2:  begin sa = 1; sbs = 2'b10; op = 3'b011; end
      4'd3:  begin io = 1; mr = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin io = 1; mw = 1; end
      4'd6:  begin sa = 1; op = 3'b010; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8, 4'd9: begin
        if (st == 4'd8) begin sa = 1; sbs = 2'b10; end
        else rw = 1;
        if (opc == 6'b001100)      begin op = 3'b100; zx = 1; end
        else if (opc == 6'b001101) begin op = 3'b101; zx = 1; end
        else if (opc == 6'b001110) begin op = 3'b110; zx = 1; end
      end
      4'd10: begin sa = 1; op = 3'b001; pwc = 1; ps = 2'b01; bn = (opc == BNE); end
      4'd11: begin pw = 1; ps = 2'b10; end
      4'd12: f = fc;
      default: ;
    endcase
    return {op, sa, sbs, zx, ps, pw, pwc, bn, io, mr, mw, irw, rw, rd, m2r, f, st};
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show in that cycle
  task automatic step(input logic rst, input logic rdy, input logic [5:0] opc,
                      input logic [3:0] st, input logic [1:0] fc);
    i_rst         = rst;
    bus.mem_ready = rdy;
    bus.opcode    = opc;
    sb.push_back(rst ? 25'd0 : model(st, opc, rdy, fc));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] opc);
    step(1'b0, 1'b1, opc, 4'd0, 2'b00);
    step(1'b0, 1'b1, opc, 4'd1, 2'b00);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("state", 32'(obs[3:0]), 32'(e[3:0]));
      check("outputs", 32'(obs), 32'(e));
    end
  end

  initial begin
    logic [5:0] imm_ops [4];
    imm_ops = '{6'b001001, 6'b001100, 6'b001101, 6'b001110};
    i_rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = R_T;
    @(posedge clk);
    #1;

    // Reset cycles: everything quiet even with ready high
    step(1'b1, 1'b0, R_T, 4'd0, 2'b00);
    step(1'b1, 1'b1, R_T, 4'd0, 2'b00);

    // R-type back to back, 4 cycles each
    repeat (2) begin
      fetch_decode(R_T);
      step(1'b0, 1'b1, R_T, 4'd6, 2'b00);
      step(1'b0, 1'b1, R_T, 4'd7, 2'b00);
    end

    // LW, ready low 3 cycles then ready on the 4th (boundary: ready wins)
    fetch_decode(LW);
    step(1'b0, 1'b1, LW, 4'd2, 2'b00);
    repeat (3) step(1'b0, 1'b0, LW, 4'd3, 2'b00);
    step(1'b0, 1'b1, LW, 4'd3, 2'b00);
    step(1'b0, 1'b1, LW, 4'd4, 2'b00);

    // SW with one wait cycle
    fetch_decode(SW);
    step(1'b0, 1'b1, SW, 4'd2, 2'b00);
    step(1'b0, 1'b0, SW, 4'd5, 2'b00);
    step(1'b0, 1'b1, SW, 4'd5, 2'b00);

    // Immediate ops
    for (int i = 0; i < 4; i++) begin
      fetch_decode(imm_ops[i]);
      step(1'b0, 1'b1, imm_ops[i], 4'd8, 2'b00);
      step(1'b0, 1'b1, imm_ops[i], 4'd9, 2'b00);
    end

    // Branches and jump
    fetch_decode(BEQ);
    step(1'b0, 1'b1, BEQ, 4'd10, 2'b00);
    fetch_decode(BNE);
    step(1'b0, 1'b1, BNE, 4'd10, 2'b00);
    fetch_decode(J_OP);
    step(1'b0, 1'b1, J_OP, 4'd11, 2'b00);

    // Illegal opcode
    fetch_decode(ILL);
    step(1'b0, 1'b1, ILL, 4'd12, 2'b01);

    // Fetch timeout: 4 wait cycles then bus fault
    repeat (4) step(1'b0, 1'b0, R_T, 4'd0, 2'b00);
    step(1'b0, 1'b0, R_T, 4'd12, 2'b10);
    // Same, but ready arrives on the 4th wait cycle
    repeat (3) step(1'b0, 1'b0, R_T, 4'd0, 2'b00);
    step(1'b0, 1'b1, R_T, 4'd0, 2'b00);
    step(1'b0, 1'b1, R_T, 4'd1, 2'b00);
    step(1'b0, 1'b1, R_T, 4'd6, 2'b00);
    step(1'b0, 1'b1, R_T, 4'd7, 2'b00);

    // Load timeout in MEM_RD
    fetch_decode(LW);
    step(1'b0, 1'b1, LW, 4'd2, 2'b00);
    repeat (4) step(1'b0, 1'b0, LW, 4'd3, 2'b00);
    step(1'b0, 1'b0, LW, 4'd12, 2'b10);

    // Reset during a store wait aborts the access
    fetch_decode(SW);
    step(1'b0, 1'b1, SW, 4'd2, 2'b00);
    repeat (2) step(1'b0, 1'b0, SW, 4'd5, 2'b00);
    step(1'b1, 1'b0, SW, 4'd0, 2'b00);
    step(1'b0, 1'b0, SW, 4'd0, 2'b00);
    step(1'b0, 1'b1, SW, 4'd0, 2'b00);
    step(1'b0, 1'b1, SW, 4'd1, 2'b00);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
